// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants and helpers for the regFile port arbiter.
// PhitSize and DwidthRfAdd carry the same values as phit_size and dwidth_RFadd
// in the shared my_interface.vh header.
package regfile_port_arbiter_pkg;

  localparam int unsigned PhitSize    = 32;
  localparam int unsigned DwidthRfAdd = 5;

  // Increment a requester index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin pick: finds the first set request bit at or after ptr, wrapping
// modulo N.
// Ports:
//   req   - request vector
//   ptr   - scan start index (0..N-1)
//   gnt   - one-hot grant of the picked bit (zero when nothing is requested)
//   idx   - index of the picked bit (zero when nothing is requested)
//   found - a request was found
module rr_arb_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one regFile (1 write port, 2 combinational read ports) among NUM_REQ
// requesters. The write port and the two read ports are allocated round-robin
// each cycle; read data is registered back to the winners one cycle later.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data     - per-requester write requests (packed)
//   wr_gnt                     - one-hot write grant (combinational)
//   rd_req/rd_addr             - per-requester read requests (packed)
//   rd_gnt                     - read grant, up to two bits (combinational)
//   rd_data/rd_vld             - registered read data and one-cycle valid
//   rf_*                       - regFile connections
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = PhitSize,
  parameter int unsigned AW      = DwidthRfAdd
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    wr_req,
  input  logic [NUM_REQ*AW-1:0] wr_addr,
  input  logic [NUM_REQ*DW-1:0] wr_data,
  output logic [NUM_REQ-1:0]    wr_gnt,
  input  logic [NUM_REQ-1:0]    rd_req,
  input  logic [NUM_REQ*AW-1:0] rd_addr,
  output logic [NUM_REQ-1:0]    rd_gnt,
  output logic [NUM_REQ*DW-1:0] rd_data,
  output logic [NUM_REQ-1:0]    rd_vld,
  output logic [DW-1:0]         rf_d_in,
  output logic [AW-1:0]         rf_wr_addr,
  output logic                  rf_wen,
  output logic [AW-1:0]         rf_rd_addr1,
  output logic [AW-1:0]         rf_rd_addr2,
  input  logic [DW-1:0]         rf_d_out1,
  input  logic [DW-1:0]         rf_d_out2
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [NUM_REQ-1:0] wr_pick_gnt, rd1_gnt, rd2_gnt;
  logic [IW-1:0]      wr_idx, rd1_idx, rd2_idx;
  logic               wr_found, rd1_found, rd2_found;

  rr_arb_pick #(.N(NUM_REQ), .IW(IW)) u_wr_pick (
    .req   (wr_req),
    .ptr   (wr_ptr_q),
    .gnt   (wr_pick_gnt),
    .idx   (wr_idx),
    .found (wr_found)
  );

  rr_arb_pick #(.N(NUM_REQ), .IW(IW)) u_rd1_pick (
    .req   (rd_req),
    .ptr   (rd_ptr_q),
    .gnt   (rd1_gnt),
    .idx   (rd1_idx),
    .found (rd1_found)
  );

  // Masking out the port1 winner and scanning from the same pointer yields
  // the second set bit in round-robin order.
  rr_arb_pick #(.N(NUM_REQ), .IW(IW)) u_rd2_pick (
    .req   (rd_req & ~rd1_gnt),
    .ptr   (rd_ptr_q),
    .gnt   (rd2_gnt),
    .idx   (rd2_idx),
    .found (rd2_found)
  );

  // Grants and regFile controls are forced idle while reset is held so that
  // nothing is written or captured during reset.
  always_comb begin
    wr_gnt      = '0;
    rf_wen      = 1'b0;
    rf_wr_addr  = '0;
    rf_d_in     = '0;
    rd_gnt      = '0;
    rf_rd_addr1 = '0;
    rf_rd_addr2 = '0;
    if (rst_n) begin
      if (wr_found) begin
        wr_gnt     = wr_pick_gnt;
        rf_wen     = 1'b1;
        rf_wr_addr = wr_addr[32'(wr_idx)*AW +: AW];
        rf_d_in    = wr_data[32'(wr_idx)*DW +: DW];
      end
      rd_gnt = rd1_gnt | rd2_gnt;
      if (rd1_found) rf_rd_addr1 = rd_addr[32'(rd1_idx)*AW +: AW];
      if (rd2_found) rf_rd_addr2 = rd_addr[32'(rd2_idx)*AW +: AW];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_found)       wr_ptr_d = IW'(wrap_inc(32'(wr_idx), NUM_REQ));
    if (rd2_found)      rd_ptr_d = IW'(wrap_inc(32'(rd2_idx), NUM_REQ));
    else if (rd1_found) rd_ptr_d = IW'(wrap_inc(32'(rd1_idx), NUM_REQ));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_data  <= '0;
      rd_vld   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_vld   <= rd1_gnt | rd2_gnt;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (rd1_gnt[k])      rd_data[k*DW +: DW] <= rf_d_out1;
        else if (rd2_gnt[k]) rd_data[k*DW +: DW] <= rf_d_out2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter with a behavioural regFile.
module tb_regfile_port_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    wr_req, wr_gnt, rd_req, rd_gnt, rd_vld;
  logic [NUM_REQ*AW-1:0] wr_addr, rd_addr;
  logic [NUM_REQ*DW-1:0] wr_data, rd_data;
  logic [DW-1:0]         rf_d_in, rf_d_out1, rf_d_out2;
  logic [AW-1:0]         rf_wr_addr, rf_rd_addr1, rf_rd_addr2;
  logic                  rf_wen;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    int unsigned k;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];
  logic [NUM_REQ-1:0] exp_vld;

  logic [DW-1:0] mem [32] = '{default: '0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_wen) mem[rf_wr_addr] <= rf_d_in;
  end
  assign rf_d_out1 = mem[rf_rd_addr1];
  assign rf_d_out2 = mem[rf_rd_addr2];

  regfile_port_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .rf_d_in     (rf_d_in),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wen      (rf_wen),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_d_out1   (rf_d_out1),
    .rf_d_out2   (rf_d_out2)
  );

  // Scoreboard monitor: each cycle, rd_vld must match exactly the reads
  // expected to land now, and each landing read must carry its data.
  always @(negedge clk) begin
    exp_vld = '0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_vld[sb[0].k] = 1'b1;
      n_checks++;
      if (rd_data[sb[0].k*DW +: DW] !== sb[0].data) begin
        n_fail++;
        $display("FAIL rd_data[%0d] cyc %0d: got %0d expected %0d", sb[0].k, cyc,
                 rd_data[sb[0].k*DW +: DW], sb[0].data);
      end
      void'(sb.pop_front());
    end
    n_checks++;
    if (rd_vld !== exp_vld) begin
      n_fail++;
      $display("FAIL rd_vld cyc %0d: got %b expected %b", cyc, rd_vld, exp_vld);
    end
  end

  task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[k*AW +: AW] = a;
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic push_rd(input int unsigned k, input logic [DW-1:0] d);
    exp_t e;
    e.due  = cyc + 1;
    e.k    = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_req = '1; rd_req = '1;
    for (int k = 0; k < 4; k++) begin set_wr(k, AW'(k), 32'hA0 + k); set_rd(k, AW'(k)); end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (wr_gnt !== 4'b0000 || rd_gnt !== 4'b0000 || rf_wen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gnt: wr_gnt=%b rd_gnt=%b rf_wen=%b expected 0", wr_gnt, rd_gnt, rf_wen);
    end
    n_checks++;
    if (rf_wr_addr !== '0 || rf_d_in !== '0 || rf_rd_addr1 !== '0 || rf_rd_addr2 !== '0) begin
      n_fail++;
      $display("FAIL reset_rf: wr_addr=%0d d_in=%0d rd1=%0d rd2=%0d expected 0",
               rf_wr_addr, rf_d_in, rf_rd_addr1, rf_rd_addr2);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (wr_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release_wr: got %b expected 0001", wr_gnt);
    end
    n_checks++;
    if (rd_gnt !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_release_rd: got %b expected 0011", rd_gnt);
    end
    // Withdraw before the edge so no transfer happens.
    wr_req = '0; rd_req = '0;
  endtask

  task automatic test_write_rr();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wr_req = 4'b1111;
      for (int k = 0; k < 4; k++) set_wr(k, AW'(k), DW'(k * 10));
      #1;
      n_checks++;
      if (wr_gnt !== 4'(1 << (c % 4)) || rf_wr_addr !== AW'(c % 4) ||
          rf_d_in !== DW'((c % 4) * 10) || rf_wen !== 1'b1) begin
        n_fail++;
        $display("FAIL write_rr c%0d: gnt=%b addr=%0d data=%0d wen=%b expected gnt=%b addr=%0d data=%0d",
                 c, wr_gnt, rf_wr_addr, rf_d_in, rf_wen, 4'(1 << (c % 4)), c % 4, (c % 4) * 10);
      end
    end
    @(negedge clk);
    wr_req = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (mem[k] !== DW'(k * 10)) begin
        n_fail++;
        $display("FAIL write_mem[%0d]: got %0d expected %0d", k, mem[k], k * 10);
      end
    end
  endtask

  task automatic test_dual_read();
    @(negedge clk);
    rd_req = 4'b0110; set_rd(1, 5'd3); set_rd(2, 5'd0);
    #1;
    n_checks++;
    if (rd_gnt !== 4'b0110 || rf_rd_addr1 !== 5'd3 || rf_rd_addr2 !== 5'd0) begin
      n_fail++;
      $display("FAIL dual_read: gnt=%b a1=%0d a2=%0d expected 0110 3 0", rd_gnt, rf_rd_addr1,
               rf_rd_addr2);
    end
    push_rd(1, 30); push_rd(2, 0);
    @(negedge clk);
    rd_req = '0;
  endtask

  task automatic test_read_fair();
    logic [3:0] exp_g [4];
    exp_g = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    // Single read from requester 3 moves the read pointer back to 0.
    @(negedge clk);
    rd_req = 4'b1000; set_rd(3, 5'd2);
    #1;
    n_checks++;
    if (rd_gnt !== 4'b1000 || rf_rd_addr1 !== 5'd2 || rf_rd_addr2 !== 5'd0) begin
      n_fail++;
      $display("FAIL single_read: gnt=%b a1=%0d a2=%0d expected 1000 2 0", rd_gnt, rf_rd_addr1,
               rf_rd_addr2);
    end
    push_rd(3, 20);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rd_req = 4'b1111;
      for (int k = 0; k < 4; k++) set_rd(k, AW'(k));
      #1;
      n_checks++;
      if (rd_gnt !== exp_g[c] || rf_rd_addr1 !== AW'((c % 2) * 2) ||
          rf_rd_addr2 !== AW'((c % 2) * 2 + 1)) begin
        n_fail++;
        $display("FAIL read_fair c%0d: gnt=%b a1=%0d a2=%0d expected %b %0d %0d", c, rd_gnt,
                 rf_rd_addr1, rf_rd_addr2, exp_g[c], (c % 2) * 2, (c % 2) * 2 + 1);
      end
      push_rd((c % 2) * 2, DW'((c % 2) * 20));
      push_rd((c % 2) * 2 + 1, DW'((c % 2) * 20 + 10));
    end
    @(negedge clk);
    rd_req = '0;
  endtask

  task automatic test_hazard();
    @(negedge clk);
    wr_req = 4'b0001; set_wr(0, 5'd5, 32'd7);
    @(negedge clk);
    wr_req = 4'b0001; set_wr(0, 5'd5, 32'd99);
    rd_req = 4'b0010; set_rd(1, 5'd5);
    #1;
    n_checks++;
    if (wr_gnt !== 4'b0001 || rd_gnt !== 4'b0010 || rf_rd_addr1 !== 5'd5 ||
        rf_rd_addr2 !== 5'd0) begin
      n_fail++;
      $display("FAIL hazard_gnt: wr=%b rd=%b a1=%0d a2=%0d expected 0001 0010 5 0", wr_gnt, rd_gnt,
               rf_rd_addr1, rf_rd_addr2);
    end
    push_rd(1, 7);
    @(negedge clk);
    wr_req = '0;
    #1;
    n_checks++;
    if (rf_wen !== 1'b0 || rd_gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL hazard_repeat: wen=%b rd=%b expected 0 0010", rf_wen, rd_gnt);
    end
    push_rd(1, 99);
    @(negedge clk);
    rd_req = '0;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rd_req = 4'b0100; set_rd(2, 5'd3);
    #1;
    push_rd(2, 30);
    @(negedge clk);
    #1;
    n_checks++;
    if (rd_gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_regrant: got %b expected 0100", rd_gnt);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_vld !== 4'b0000 || rd_gnt !== 4'b0000 || wr_gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_clear: vld=%b rd_gnt=%b wr_gnt=%b expected 0", rd_vld, rd_gnt, wr_gnt);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    rd_req = 4'b1010; set_rd(1, 5'd3); set_rd(3, 5'd1);
    wr_req = 4'b0110; set_wr(1, 5'd8, 32'd55); set_wr(2, 5'd9, 32'd66);
    #1;
    n_checks++;
    if (wr_gnt !== 4'b0010 || rf_wr_addr !== 5'd8 || rf_d_in !== 32'd55) begin
      n_fail++;
      $display("FAIL midrst_wr: gnt=%b addr=%0d data=%0d expected 0010 8 55", wr_gnt, rf_wr_addr,
               rf_d_in);
    end
    n_checks++;
    if (rd_gnt !== 4'b1010 || rf_rd_addr1 !== 5'd3 || rf_rd_addr2 !== 5'd1) begin
      n_fail++;
      $display("FAIL midrst_rd: gnt=%b a1=%0d a2=%0d expected 1010 3 1", rd_gnt, rf_rd_addr1,
               rf_rd_addr2);
    end
    push_rd(1, 30); push_rd(3, 10);
    @(negedge clk);
    rd_req = '0; wr_req = '0;
    #1;
    n_checks++;
    if (mem[8] !== 32'd55) begin
      n_fail++;
      $display("FAIL midrst_mem: got %0d expected 55", mem[8]);
    end
  endtask

  initial begin
    wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    rst_n = 1'b0;
    test_reset();
    test_write_rr();
    test_dual_read();
    test_read_fair();
    test_hazard();
    test_mid_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
